// File: rtl/e2prom_sched_pkg.sv
// Shared types and constants for the EEPROM button scheduler.
// Timeout watchdog enabled by E2PROM_BTN_SCHED_TIMEOUT_EN.
package e2prom_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/e2prom_req_latch.sv
// Pending-command flag for one button pulse.
// Set has priority over clear so a press is never lost.
module e2prom_req_latch
(
  input  logic i_Clock10MHz,
  input  logic i_Rst_n,
  input  logic i_Set,
  input  logic i_Clr,
  output logic o_Pend
);

  logic r_Pend;

  always_ff @(posedge i_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Pend <= 1'b0;
    end else if (i_Set) begin
      r_Pend <= 1'b1;
    end else if (i_Clr) begin
      r_Pend <= 1'b0;
    end
  end

  assign o_Pend = r_Pend;

endmodule

// File: rtl/e2prom_btn_sched.sv
// Button-command scheduler in front of the I2C EEPROM master.
// Optional watchdog: define E2PROM_BTN_SCHED_TIMEOUT_EN.
module e2prom_btn_sched
  import e2prom_sched_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)
(
  input  logic              i_Clock10MHz,
  input  logic              i_Rst_n,
  input  logic              i_Wr_Pulse,
  input  logic              i_Rd_Pulse,
  input  logic              i_Inc_Pulse,
  output logic              o_Req,
  output logic              o_Rw,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_Wdata,
  input  logic              i_Ack,
  input  logic              i_Done,
  input  logic              i_Err,
  input  logic [DATA_W-1:0] i_Rdata,
  output logic [DATA_W-1:0] o_Rdata,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Err
);

  if (TIMEOUT_CYC < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 2");
  end

  sched_state_t r_State;
  sched_state_t w_Next;

  logic [ADDR_W-1:0] r_Addr;
  logic [DATA_W-1:0] r_Wdata;
  logic [DATA_W-1:0] r_Rdata;
  logic              r_Rw;
  logic              r_Err;

  logic w_Pend_Wr;
  logic w_Pend_Rd;
  logic w_Pend_Inc;
  logic w_Clr_Wr;
  logic w_Clr_Rd;
  logic w_Clr_Inc;
  logic w_Load_Rw;
  logic w_Rw_Val;
  logic w_Ok;
  logic w_Fail;
  logic w_Tmo;

  e2prom_req_latch u_wr (
    .i_Clock10MHz (i_Clock10MHz),
    .i_Rst_n      (i_Rst_n),
    .i_Set        (i_Wr_Pulse),
    .i_Clr        (w_Clr_Wr),
    .o_Pend       (w_Pend_Wr)
  );

  e2prom_req_latch u_rd (
    .i_Clock10MHz (i_Clock10MHz),
    .i_Rst_n      (i_Rst_n),
    .i_Set        (i_Rd_Pulse),
    .i_Clr        (w_Clr_Rd),
    .o_Pend       (w_Pend_Rd)
  );

  e2prom_req_latch u_inc (
    .i_Clock10MHz (i_Clock10MHz),
    .i_Rst_n      (i_Rst_n),
    .i_Set        (i_Inc_Pulse),
    .i_Clr        (w_Clr_Inc),
    .o_Pend       (w_Pend_Inc)
  );

`ifdef E2PROM_BTN_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_Tmo_Cnt;

  always_ff @(posedge i_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Tmo_Cnt <= '0;
    end else if (w_Load_Rw) begin
      r_Tmo_Cnt <= '0;
    end else if (r_State == REQ || r_State == WAIT) begin
      r_Tmo_Cnt <= r_Tmo_Cnt + CNT_W'(1);
    end
  end

  assign w_Tmo = (r_Tmo_Cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_Tmo = 1'b0;
`endif

  always_ff @(posedge i_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_Next;
    end
  end

  // Increment beats write beats read; only one grant per cycle.
  always_comb begin
    w_Next    = r_State;
    w_Clr_Wr  = 1'b0;
    w_Clr_Rd  = 1'b0;
    w_Clr_Inc = 1'b0;
    w_Load_Rw = 1'b0;
    w_Rw_Val  = RW_WRITE;
    w_Ok      = 1'b0;
    w_Fail    = 1'b0;
    unique case (r_State)
      IDLE: begin
        if (w_Pend_Inc) begin
          w_Clr_Inc = 1'b1;
        end else if (w_Pend_Wr) begin
          w_Clr_Wr  = 1'b1;
          w_Load_Rw = 1'b1;
          w_Rw_Val  = RW_WRITE;
          w_Next    = REQ;
        end else if (w_Pend_Rd) begin
          w_Clr_Rd  = 1'b1;
          w_Load_Rw = 1'b1;
          w_Rw_Val  = RW_READ;
          w_Next    = REQ;
        end
      end
      REQ: begin
        if (i_Ack) begin
          w_Next = WAIT;
        end else if (w_Tmo) begin
          w_Fail = 1'b1;
          w_Next = DONE;
        end
      end
      WAIT: begin
        if (i_Done) begin
          w_Ok   = !i_Err;
          w_Fail = i_Err;
          w_Next = DONE;
        end else if (w_Tmo) begin
          w_Fail = 1'b1;
          w_Next = DONE;
        end
      end
      DONE: begin
        w_Next = IDLE;
      end
      default: begin
        w_Next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock10MHz or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Addr  <= '0;
      r_Wdata <= '0;
      r_Rdata <= '0;
      r_Rw    <= RW_WRITE;
      r_Err   <= 1'b0;
    end else begin
      if (w_Clr_Inc) begin
        r_Addr <= r_Addr + ADDR_W'(1);
      end
      if (w_Load_Rw) begin
        r_Rw <= w_Rw_Val;
      end
      if (w_Ok) begin
        if (r_Rw == RW_READ) begin
          r_Rdata <= i_Rdata;
        end else begin
          r_Wdata <= r_Wdata + DATA_W'(1);
        end
        r_Err <= 1'b0;
      end
      if (w_Fail) begin
        r_Err <= 1'b1;
      end
    end
  end

  assign o_Req   = (r_State == REQ);
  assign o_Busy  = (r_State != IDLE);
  assign o_Done  = (r_State == DONE);
  assign o_Rw    = r_Rw;
  assign o_Addr  = r_Addr;
  assign o_Wdata = r_Wdata;
  assign o_Rdata = r_Rdata;
  assign o_Err   = r_Err;

endmodule

// File: doc/e2prom_btn_sched.md
# e2prom_btn_sched

Button-command scheduler between the three debounced button pulse outputs and the I2C EEPROM master's request port. It latches single-cycle press pulses, arbitrates between pending commands, and maintains the current EEPROM address and the write-data pattern. It sequences one EEPROM transaction at a time through a req/ack/done handshake and holds the last read byte for the display logic.

## Interface
Parameters:
- ADDR_W, 8, EEPROM word-address width.
- DATA_W, 8, data byte width.
- TIMEOUT_CYC, 100000, watchdog limit in clocks (10 ms at 10 MHz). Used only with the timeout feature.

Ports:
- i_Clock10MHz  in  1  system clock, 10 MHz.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Wr_Pulse  in  1  one-cycle press pulse: write request.
- i_Rd_Pulse  in  1  one-cycle press pulse: read request.
- i_Inc_Pulse  in  1  one-cycle press pulse: address increment.
- o_Req  out  1  transaction request to the I2C master.
- o_Rw  out  1  1 = read, 0 = write; valid while o_Req = 1.
- o_Addr  out  ADDR_W  current EEPROM address.
- o_Wdata  out  DATA_W  write-data pattern register.
- i_Ack  in  1  master accepted the request (one cycle).
- i_Done  in  1  transaction complete (one cycle).
- i_Err  in  1  NACK/bus error; qualified by i_Done.
- i_Rdata  in  DATA_W  read byte; qualified by i_Done.
- o_Rdata  out  DATA_W  last successfully read byte.
- o_Busy  out  1  FSM is not in IDLE.
- o_Done  out  1  one-cycle completion strobe.
- o_Err  out  1  status of the last transaction.

Reset values: o_Req, o_Rw, o_Busy, o_Done and o_Err are 0. o_Addr, o_Wdata and o_Rdata are all zeros. All pending flags are clear. The FSM is in IDLE.

## Operation
- **Pending flags.** There are three flags: wr, rd and inc. Each flag is set by its pulse. It is cleared when its command is granted. If a pulse arrives in the same cycle as a clear of the same flag, the set wins. A pulse arriving while its flag is already set is absorbed and not counted.
- **IDLE arbitration.** Checked once per cycle, in this order:
  - inc pending: o_Addr <= o_Addr + 1, wrapping from all-ones to 0. Clear inc and stay in IDLE.
  - else wr pending: set o_Rw = 0, clear wr, go to REQ.
  - else rd pending: set o_Rw = 1, clear rd, go to REQ.
- **Address stability.** An inc that arrives during a transaction stays pending. It is applied only after the FSM returns to IDLE, so o_Addr is stable from REQ through DONE.
- **REQ.** o_Req = 1. It is held until i_Ack is sampled high, then the FSM goes to WAIT and o_Req drops.
- **WAIT.** The FSM waits for i_Done.
  - i_Done with i_Err = 0: for a read, o_Rdata <= i_Rdata; for a write, o_Wdata <= o_Wdata + 1 (wraps). Then o_Err <= 0.
  - i_Done with i_Err = 1: o_Err <= 1; o_Rdata and o_Wdata are unchanged.
  - In both cases the FSM goes to DONE.
- **DONE.** o_Done = 1 for exactly one cycle, then IDLE.
- **Ignored strobes.** i_Ack outside REQ and i_Done outside WAIT are ignored.
- **Reset mid-transaction.** Everything returns to reset values immediately. The I2C master shares the same reset.

## Timing
- **Pulse to request.** A pulse sampled at edge k sets its flag at edge k. The FSM leaves IDLE at edge k+1, and o_Req is high after edge k+1 (2-cycle latency).
- **Increment latency.** An inc pulse at edge k updates o_Addr at edge k+1 when the FSM is idle.
- **Handshake.** i_Ack in the first REQ cycle means o_Req lasts exactly 1 cycle. i_Done and i_Ack in the same cycle are not legal from the master.
- **Completion.** i_Done at edge m: the FSM enters DONE at edge m, and o_Done is high between edges m and m+1. The earliest next o_Req is after edge m+2.
- **Back-to-back commands.** Simultaneous wr and rd pulses cause two transactions in sequence: the write first, then the read.

## Configuration
- **Macro E2PROM_BTN_SCHED_TIMEOUT_EN defined.**
  - A counter is cleared on entry to REQ and counts in REQ and WAIT.
  - When it reaches TIMEOUT_CYC-1 with neither i_Ack (in REQ) nor i_Done (in WAIT), the transaction is aborted: o_Req drops, o_Err <= 1, data registers are unchanged, and the FSM goes to DONE.
- **Macro not defined.** There is no counter, and REQ and WAIT wait indefinitely.

## Structure
- **Package e2prom_sched_pkg.**
  - State enum: IDLE, REQ, WAIT, DONE.
  - Constants: RW_READ = 1, RW_WRITE = 0, and the default TIMEOUT_CYC.
- **Sub-module e2prom_req_latch.** One instance per button: a set/clear pending flag with set-priority. All other logic lives in the top module.

## Test plan
- **Write then read.** Press Inc twice, then Wr. Expected: o_Addr = 2, o_Rw = 0, and after i_Done o_Wdata = 1. Then press Rd with i_Rdata = 8'h00. Expected: o_Rdata = 8'h00, o_Err = 0.
- **Simultaneous Wr and Rd.** Pulse Wr and Rd in the same cycle. Expected: two transactions, write first, then read, with one o_Done per transaction.
- **Inc during WAIT.** Pulse Inc while in WAIT at address 5. Expected: o_Addr stays 5 until DONE, then becomes 6 one cycle after returning to IDLE.
- **Address wrap.** Press Inc at address 8'hFF. Expected: o_Addr = 8'h00.
- **NACK.** Return i_Done with i_Err = 1 on a read. Expected: o_Err = 1 and o_Rdata unchanged. A following successful write clears o_Err to 0.
- **Timeout (macro defined, TIMEOUT_CYC = 16).** Withhold i_Ack. Expected: o_Req drops after 16 cycles, o_Err = 1, o_Done pulses once. Also assert reset mid-WAIT and check all outputs return to zero.
